cla_pipe_adder: RTL and testbench



---
 rtl/cla_pipe_adder.sv | 231 +++++++++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
//   Pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups.
//   Stage k resolves GPS consecutive 4-bit groups. Its group carry-out, its
//   resolved low sum bits and the still-unresolved upper operand bits are
//   registered and handed to stage k+1. Latency is STAGES cycles. A global
//   stall freezes every stage while the result is not taken.
//
//   Parameters
//     WIDTH   operand/sum width, multiple of 4, 4..64
//     STAGES  pipeline register stages (= latency), must divide WIDTH/4
//
//   Ports
//     clk, reset         rising-edge clock, synchronous active-high reset
//     i_valid / i_ready  input handshake; i_ready = ~(o_valid & ~o_ready)
//     i_a, i_b           operands
//     i_ci               carry-in (add) / borrow-in (subtract)
//     i_sub              0 = a + b + ci, 1 = a - b - borrow
//     o_valid / o_ready  output handshake
//     o_s, o_co          sum/difference, carry-out (subtract: 1 = no borrow)
//     o_zero, o_neg,     result flags; generated only when the macro
//     o_ovf              CLA_PIPE_FLAGS_EN is defined, otherwise tied to 0
// -----------------------------------------------------------------------------
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_co,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_ovf
);

  localparam int GPS = WIDTH / 4 / STAGES;  // groups resolved per stage
  localparam int SW  = 4 * GPS;             // bits resolved per stage

  // 4-bit carry-lookahead group: returns {c4, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic c0);
    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       c4;
    p  = a ^ b;
    g  = a & b;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c4, p ^ {c3, c2, c1, c0}};
  endfunction

  logic              stall_s;
  logic              accept_s;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] v_q;

  assign stall_s  = v_q[STAGES-1] & ~o_ready;
  assign i_ready  = ~stall_s;
  assign accept_s = i_valid & ~stall_s;
  assign o_valid  = v_q[STAGES-1];

  // Valid bits shift one stage per cycle unless stalled; bubbles are kept.
  always_comb begin
    v_d = v_q;
    if (!stall_s) begin
      v_d = (v_q << 1'b1) | STAGES'(accept_s);
    end else begin
      v_d = v_q;
    end
  end

  // Stage valid register.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SW;     // first bit resolved by this stage
    localparam int IW = WIDTH - LO; // operand bits still unresolved on entry
    localparam int HI = LO + SW;    // sum bits known after this stage

    logic [IW-1:0] a_in_s;
    logic [IW-1:0] b_in_s;          // already inverted for subtract
    logic          c_in_s;
    logic          ld_s;            // a valid operation enters this stage
    logic [SW-1:0] grp_sum_s;
    logic          cc_s;
    logic [4:0]    grp_r_s;
    logic [HI-1:0] s_d;
    logic [HI-1:0] s_q;
    logic          c_d;
    logic          c_q;

    if (k == 0) begin : g_src
      // Subtract is a + ~b + ~borrow, so both b and the carry-in flip.
      assign a_in_s = i_a;
      assign b_in_s = i_b ^ {WIDTH{i_sub}};
      assign c_in_s = i_ci ^ i_sub;
      assign ld_s   = accept_s;
      assign s_d    = grp_sum_s;
    end else begin : g_src
      assign a_in_s = g_stage[k-1].g_fwd.a_q;
      assign b_in_s = g_stage[k-1].g_fwd.b_q;
      assign c_in_s = g_stage[k-1].c_q;
      assign ld_s   = v_q[k-1] & ~stall_s;
      assign s_d    = {grp_sum_s, g_stage[k-1].s_q};
    end

    // Chain the group carries through this stage's GPS groups.
    always_comb begin
      cc_s      = c_in_s;
      grp_r_s   = 5'd0;
      grp_sum_s = '0;
      for (int g = 0; g < GPS; g++) begin
        grp_r_s              = cla4(a_in_s[4*g +: 4], b_in_s[4*g +: 4], cc_s);
        grp_sum_s[4*g +: 4]  = grp_r_s[3:0];
        cc_s                 = grp_r_s[4];
      end
      c_d = cc_s;
    end

    // Resolved sum bits and stage carry-out; loaded only by a valid entry so
    // bubbles leave the last result in place.
    always_ff @(posedge clk) begin
      if (reset) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (ld_s) begin
        s_q <= s_d;
        c_q <= c_d;
      end else begin
        s_q <= s_q;
        c_q <= c_q;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      localparam int FW = IW - SW;
      logic [FW-1:0] a_d;
      logic [FW-1:0] a_q;
      logic [FW-1:0] b_d;
      logic [FW-1:0] b_q;

      // Upper operand bits not yet consumed.
      always_comb begin
        a_d = a_in_s[IW-1:SW];
        b_d = b_in_s[IW-1:SW];
      end

      // Forwarded operand registers.
      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld_s) begin
          a_q <= a_d;
          b_q <= b_d;
        end else begin
          a_q <= a_q;
          b_q <= b_q;
        end
      end
    end

    if (k == STAGES - 1) begin : g_out
      assign o_s  = s_q;
      assign o_co = c_q;
`ifdef CLA_PIPE_FLAGS_EN
      logic zero_d;
      logic zero_q;
      logic neg_d;
      logic neg_q;
      logic ovf_d;
      logic ovf_q;

      // Flags from the final sum; the carry into the MSB is recovered as
      // s ^ a ^ b' at that bit, so overflow is carry-in(MSB) ^ carry-out.
      always_comb begin
        zero_d = (s_d == '0);
        neg_d  = s_d[WIDTH-1];
        ovf_d  = (s_d[WIDTH-1] ^ a_in_s[IW-1] ^ b_in_s[IW-1]) ^ c_d;
      end

      // Flag registers, loaded together with the final sum.
      always_ff @(posedge clk) begin
        if (reset) begin
          zero_q <= 1'b0;
          neg_q  <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (ld_s) begin
          zero_q <= zero_d;
          neg_q  <= neg_d;
          ovf_q  <= ovf_d;
        end else begin
          zero_q <= zero_q;
          neg_q  <= neg_q;
          ovf_q  <= ovf_q;
        end
      end

      assign o_zero = zero_q;
      assign o_neg  = neg_q;
      assign o_ovf  = ovf_q;
`else
      assign o_zero = 1'b0;
      assign o_neg  = 1'b0;
      assign o_ovf  = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_adder
//   Scoreboard bench for cla_pipe_adder (WIDTH=32, STAGES=2). Each accepted
//   operation pushes the value computed by a plain-arithmetic reference model;
//   a monitor compares every presented result against the queue head and pops
//   it when the result is taken.
// -----------------------------------------------------------------------------
module tb_cla_pipe_adder;
  localparam int WIDTH  = 32;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_ci;
  logic             i_sub;
  logic             o_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_s;
  logic             o_co;
  logic             o_zero;
  logic             o_neg;
  logic             o_ovf;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        zero;
    logic        neg;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_push   = 0;
  int   n_pop    = 0;
  logic done;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_a(i_a), .i_b(i_b), .i_ci(i_ci), .i_sub(i_sub),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_s(o_s), .o_co(o_co),
    .o_zero(o_zero), .o_neg(o_neg), .o_ovf(o_ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: integer arithmetic on the operands, signed range for overflow.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sub);
    exp_t        e;
    logic [63:0] r;
    longint      sa;
    longint      sbv;
    longint      sr;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (sub) begin
      r  = {32'd0, a} + 64'h1_0000_0000 - {32'd0, b} - {63'd0, ci};
      sr = sa - sbv - longint'(ci);
    end else begin
      r  = {32'd0, a} + {32'd0, b} + {63'd0, ci};
      sr = sa + sbv + longint'(ci);
    end
    e.s  = r[31:0];
    e.co = r[32];
`ifdef CLA_PIPE_FLAGS_EN
    e.zero = (e.s == 32'd0);
    e.neg  = e.s[31];
    e.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`else
    e.zero = 1'b0;
    e.neg  = 1'b0;
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0:       v = 32'h0000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Monitor: compare whatever is presented; pop only when it is taken.
  always @(negedge clk) begin
    exp_t e;
    if (reset !== 1'b1 && o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output o_s=%h required=none", o_s);
      end else begin
        e = sb[0];
        chk("sum", 64'(o_s), 64'(e.s));
        chk("carry", 64'(o_co), 64'(e.co));
        chk("flags", 64'({o_zero, o_neg, o_ovf}), 64'({e.zero, e.neg, e.ovf}));
        if (o_ready === 1'b1) begin
          void'(sb.pop_front());
          n_pop++;
        end
      end
    end
  end

  // Present one operation until accepted; returns 1 time unit after the edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sub);
    int waited = 0;
    i_a = a; i_b = b; i_ci = ci; i_sub = sub; i_valid = 1'b1;
    @(negedge clk);
    while (i_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (i_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout i_ready=%b required=1", i_ready);
    end else begin
      sb.push_back(model(a, b, ci, sub));
      n_push++;
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until o_valid, counting that edge as 1.
  task automatic check_latency();
    int lat = 1;
    @(negedge clk);
    while (o_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", 64'(lat), 64'(STAGES));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_a = 32'd0; i_b = 32'd0;
    i_ci = 1'b0; i_sub = 1'b0; o_ready = 1'b1; done = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_s", 64'(o_s), 64'd0);
    chk("rst_o_co", 64'(o_co), 64'd0);
    chk("rst_flags", 64'({o_zero, o_neg, o_ovf}), 64'd0);
    chk("rst_i_ready", 64'(i_ready), 64'd1);
    @(posedge clk);
    #1;

    // Simple add with latency measurement.
    issue(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
    check_latency();
    drain();

    // Full carry ripple, then subtract cases.
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    drain();
    issue(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1);
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    drain();

    // Back-to-back stream of 8 with a 3-cycle downstream stall mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          issue($urandom, $urandom, 1'($urandom), 1'($urandom));
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 o_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_o_valid", 64'(o_valid), 64'd1);
          chk("stall_i_ready", 64'(i_ready), 64'd0);
          @(posedge clk);
          #1;
        end
        o_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", 64'(n_pop), 64'(n_push));

    // Reset with two operations in flight.
    o_ready = 1'b0;
    issue($urandom, $urandom, 1'b0, 1'b0);
    issue($urandom, $urandom, 1'b1, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_push = n_push - sb.size();
    sb.delete();
    o_ready = 1'b1;
    @(negedge clk);
    chk("flush_o_valid", 64'(o_valid), 64'd0);
    chk("flush_i_ready", 64'(i_ready), 64'd1);
    @(posedge clk);
    #1;
    issue(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    check_latency();
    drain();

    // Random traffic with random gaps and random downstream back-pressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          issue(rand_op(), rand_op(), 1'($urandom), 1'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          o_ready = ($urandom_range(0, 3) != 0);
        end
        o_ready = 1'b1;
      end
    join
    drain();
    chk("total_count", 64'(n_pop), 64'(n_push));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
